dmem_responder: RTL

Multi-cycle data-memory responder serving load/store requests from the processor core over a valid/ready request channel and a valid/ready response channel. It replaces the zero-latency data memory when the core is moved to a stalling memory interface. It holds a word-organised 64-bit memory array and inserts a parameterised number of wait states per access. It flags misaligned or out-of-range accesses instead of performing them.

---
 rtl/dmem_responder.sv | 115 +++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one load/store at a time over valid/ready
// request and response channels, with WAIT_CYCLES wait states before each access.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_error
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [CW-1:0]  cnt_q;
  logic           wr_q;
  logic [63:0]    addr_q;
  logic [63:0]    wdata_q;
  logic [63:0]    mem [DEPTH_WORDS];

  logic [AW-1:0]  idx;
  logic           access_err;
  logic           access_now;

  // Out-of-range means any address bit above the top word-index bit is set.
  assign idx        = addr_q[AW+2:3];
  assign access_err = (addr_q[2:0] != 3'b000) || (|addr_q[63:AW+3]);
  assign access_now = (state_q == WAIT) && (cnt_q == '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge CLK) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid && req_ready) state_d = WAIT;
      WAIT:    if (cnt_q == '0)            state_d = RESP;
      RESP:    if (resp_ready)             state_d = IDLE;
      default:                             state_d = IDLE;
    endcase
  end

  // Handshake outputs depend on state only, never on inputs.
  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == RESP);
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid && req_ready) begin
            wr_q    <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt_q   <= CW'(WAIT_CYCLES);
          end
        end
        WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            resp_error <= access_err;
            resp_rdata <= (!wr_q && !access_err) ? mem[idx] : '0;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_rdata <= '0;
            resp_error <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the array has no reset; contents must survive reset, and a store is
  // still gated by reset so an edge with reset asserted never commits it.
  always_ff @(posedge CLK) begin
    if (!reset && access_now && wr_q && !access_err) begin
      mem[idx] <= wdata_q;
    end
  end

endmodule
